// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the instruction memory.
// Parses a sync/length/payload/checksum frame, writes each assembled
// little-endian word into the instruction memory and keeps the core held
// in reset until a complete image has been stored and its XOR checksum
// has matched.
module imem_loader #(
  parameter int D_SIZE  = 32,  // instruction word width
  parameter int AD_SIZE = 32,  // instruction memory byte-address width
  parameter int DEPTH   = 32   // memory capacity in words, largest legal N
) (
  input  logic               clk,
  input  logic               rst,          // synchronous, active-low
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               im_we,
  output logic [AD_SIZE-1:0] im_addr,
  output logic [D_SIZE-1:0]  im_wdata,
  output logic               core_hold,
  output logic               done,
  output logic               err,
  output logic [15:0]        words_loaded
);

  // Frame start marker; it is the only byte that leaves IDLE, DONE or ERROR.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Capacity widened by one bit so the N > DEPTH test can never overflow.
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

  // ---------------------------------------------------------------------
  // Frame-tracking state
  // ---------------------------------------------------------------------
  state_e              state_q,    state_d;
  logic [15:0]         n_q,        n_d;         // word count of this frame
  logic [1:0]          byte_cnt_q, byte_cnt_d;  // byte lane within the word
  logic [D_SIZE-1:0]   word_q,     word_d;      // word being assembled
  logic [7:0]          acc_q,      acc_d;       // running payload XOR
  logic [15:0]         words_q,    words_d;     // words written so far

  // ---------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------
  logic                in_ready_q,  in_ready_d;
  logic                im_we_q,     im_we_d;
  logic [AD_SIZE-1:0]  im_addr_q,   im_addr_d;
  logic [D_SIZE-1:0]   im_wdata_q,  im_wdata_d;
  logic                core_hold_q, core_hold_d;
  logic                done_q,      done_d;
  logic                err_q,       err_d;

  // Helper terms
  logic        accept;     // a byte is transferred at the coming edge
  logic        is_sync;    // the byte on the bus is the frame marker
  logic [15:0] n_full;     // word count once the high byte arrives
  logic        len_bad;    // zero-length or oversized image
  logic [15:0] words_inc;  // word count after the current write

  // Transfer qualifier and length decode shared by the next-state logic.
  always_comb begin
    accept    = in_valid && in_ready_q;
    is_sync   = (in_data == SYNC_BYTE);
    n_full    = {in_data, n_q[7:0]};
    len_bad   = (n_full == 16'd0) || ({1'b0, n_full} > DEPTH_W);
    words_inc = words_q + 16'd1;
  end

  // Frame parser: next state, counters, word assembly and checksum.
  always_comb begin
    // NOTE: every variable gets its hold value before any branch so no
    // path through the case leaves one unassigned, which would infer a latch.
    state_d    = state_q;
    n_d        = n_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    acc_d      = acc_q;
    words_d    = words_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        // Anything but the marker is discarded; the marker starts a fresh
        // frame with all per-frame counters cleared.
        if (accept && is_sync) begin
          state_d    = S_LEN_LO;
          byte_cnt_d = 2'd0;
          acc_d      = 8'h00;
          words_d    = 16'd0;
        end
      end

      S_LEN_LO: begin
        if (accept) begin
          n_d     = {8'h00, in_data};
          state_d = S_LEN_HI;
        end
      end

      S_LEN_HI: begin
        if (accept) begin
          n_d     = n_full;
          state_d = len_bad ? S_ERROR : S_DATA;
        end
      end

      S_DATA: begin
        // Little-endian: lane 0 is bits 7:0 of the word.
        if (accept) begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
          acc_d      = acc_q ^ in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        // Single bubble cycle: the input is stalled while the word is
        // presented to the memory, then the count advances.
        words_d = words_inc;
        state_d = (words_inc == n_q) ? S_CHECK : S_DATA;
      end

      S_CHECK: begin
        if (accept) begin
          state_d = (in_data == acc_q) ? S_DONE : S_ERROR;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every port is a plain flop.
  always_comb begin
    in_ready_d  = (state_d != S_WRITE);
    im_we_d     = (state_d == S_WRITE);
    im_addr_d   = im_addr_q;
    im_wdata_d  = im_wdata_q;
    core_hold_d = (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERROR);

    // Address and data are captured only when a write is launched and hold
    // their last values otherwise; the strobe alone qualifies them.
    if (state_d == S_WRITE && state_q != S_WRITE) begin
      im_addr_d  = AD_SIZE'({words_q, 2'b00});
      im_wdata_d = word_d;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state_q     <= S_IDLE;
      n_q         <= 16'd0;
      byte_cnt_q  <= 2'd0;
      word_q      <= '0;
      acc_q       <= 8'h00;
      words_q     <= 16'd0;
      in_ready_q  <= 1'b0;
      im_we_q     <= 1'b0;
      im_addr_q   <= '0;
      im_wdata_q  <= '0;
      core_hold_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      acc_q       <= acc_d;
      words_q     <= words_d;
      in_ready_q  <= in_ready_d;
      im_we_q     <= im_we_d;
      im_addr_q   <= im_addr_d;
      im_wdata_q  <= im_wdata_d;
      core_hold_q <= core_hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign im_we        = im_we_q;
  assign im_addr      = im_addr_q;
  assign im_wdata     = im_wdata_q;
  assign core_hold    = core_hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames with hand-computed expected memory writes,
// status flags and timing for imem_loader.
module tb_imem_loader;

  localparam int D_SIZE  = 32;
  localparam int AD_SIZE = 32;
  localparam int DEPTH   = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic [7:0]         in_data = 8'h00;
  logic               in_ready;
  logic               im_we;
  logic [AD_SIZE-1:0] im_addr;
  logic [D_SIZE-1:0]  im_wdata;
  logic               core_hold;
  logic               done;
  logic               err;
  logic [15:0]        words_loaded;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  frame_q[$];
  logic [7:0]  img[128];
  logic [7:0]  cks;

  imem_loader #(.D_SIZE(D_SIZE), .AD_SIZE(AD_SIZE), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .core_hold    (core_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Log every memory write, sampled mid-cycle; the input must be stalled then.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wr_addr.push_back(im_addr);
      wr_data.push_back(im_wdata);
      check("ready_low_in_write", {31'd0, in_ready}, 32'd0);
    end
  end

  // Present one byte (after an optional random idle gap) until accepted.
  // Returns 1 time unit after the accepting edge with in_valid low.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    bit ok  = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input int max_gap);
    foreach (frame_q[i]) send_byte(frame_q[i], max_gap);
    frame_q.delete();
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  // Status flags in one shot: {core_hold, done, err}.
  task automatic check_status(input string tag, input logic [2:0] exp);
    check(tag, {29'd0, core_hold, done, err}, {29'd0, exp});
  endtask

  // Expected writes of the basic two-word image.
  task automatic check_basic_writes(input string tag);
    check({tag, "_nwr"}, wr_addr.size(), 32'd2);
    if (wr_addr.size() >= 2) begin
      check({tag, "_a0"}, wr_addr[0], 32'h0000_0000);
      check({tag, "_d0"}, wr_data[0], 32'h0500_0820);
      check({tag, "_a1"}, wr_addr[1], 32'h0000_0004);
      check({tag, "_d1"}, wr_data[1], 32'h0800_0000);
    end
  endtask

  task automatic push_basic_body();
    // N=2, words 0x05000820 and 0x08000000, little-endian.
    frame_q.push_back(8'h02); frame_q.push_back(8'h00);
    frame_q.push_back(8'h20); frame_q.push_back(8'h08);
    frame_q.push_back(8'h00); frame_q.push_back(8'h05);
    frame_q.push_back(8'h00); frame_q.push_back(8'h00);
    frame_q.push_back(8'h00); frame_q.push_back(8'h08);
  endtask

  initial begin
    // ---------------- reset values ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_im_we", {31'd0, im_we}, 32'd0);
    check("rst_im_addr", im_addr, 32'd0);
    check("rst_im_wdata", im_wdata, 32'd0);
    check_status("rst_status", 3'b100);
    check("rst_words", {16'd0, words_loaded}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // ---------------- noise then basic load ----------------
    clear_log();
    frame_q.push_back(8'h00); frame_q.push_back(8'hFF);
    frame_q.push_back(8'h5A); frame_q.push_back(8'hA5);
    push_basic_body();
    send_frame(0);
    check_status("basic_before_cks", 3'b100);
    // 20^08^00^05^00^00^00^08 = 0x25
    send_byte(8'h25, 0);
    check_status("basic_release", 3'b010);
    check("basic_words", {16'd0, words_loaded}, 32'd2);
    check_basic_writes("basic");

    // ---------------- junk after DONE, then restart ----------------
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    check_status("done_ignores_junk", 3'b010);
    send_byte(8'hA5, 0);
    check_status("restart_holds", 3'b100);

    // ---------------- checksum mismatch ----------------
    clear_log();
    push_basic_body();
    send_frame(0);
    send_byte(8'h24, 0);
    check_status("bad_cks", 3'b101);
    check_basic_writes("bad_cks");

    // ---------------- recovery from ERROR ----------------
    clear_log();
    // checksum = 11^22^33^44 = 0x44
    frame_q.push_back(8'hA5); frame_q.push_back(8'h01); frame_q.push_back(8'h00);
    frame_q.push_back(8'h11); frame_q.push_back(8'h22);
    frame_q.push_back(8'h33); frame_q.push_back(8'h44);
    frame_q.push_back(8'h44);
    send_frame(0);
    check_status("recover", 3'b010);
    check("recover_nwr", wr_addr.size(), 32'd1);
    if (wr_addr.size() >= 1) begin
      check("recover_a0", wr_addr[0], 32'h0);
      check("recover_d0", wr_data[0], 32'h4433_2211);
    end

    // ---------------- length bounds ----------------
    clear_log();
    frame_q.push_back(8'hA5); frame_q.push_back(8'h00); frame_q.push_back(8'h00);
    send_frame(0);
    check_status("len_zero", 3'b101);
    frame_q.push_back(8'hA5); frame_q.push_back(8'h21); frame_q.push_back(8'h00);
    send_frame(0);
    check_status("len_over", 3'b101);
    repeat (2) @(posedge clk);
    #1;
    check("len_err_nwr", wr_addr.size(), 32'd0);

    // ---------------- full-depth image ----------------
    clear_log();
    cks = 8'h00;
    for (int j = 0; j < 128; j++) begin
      img[j] = 8'(j * 7 + 1);
      cks    = cks ^ img[j];
    end
    frame_q.push_back(8'hA5); frame_q.push_back(8'h20); frame_q.push_back(8'h00);
    for (int j = 0; j < 128; j++) frame_q.push_back(img[j]);
    frame_q.push_back(cks);
    send_frame(0);
    check_status("full_release", 3'b010);
    check("full_words", {16'd0, words_loaded}, 32'd32);
    check("full_nwr", wr_addr.size(), 32'd32);
    if (wr_addr.size() == 32) begin
      for (int i = 0; i < 32; i++) begin
        check("full_addr", wr_addr[i], 32'(i * 4));
        check("full_data", wr_data[i],
              {img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]});
      end
      check("full_last_addr", wr_addr[31], 32'h7C);
    end

    // ---------------- random gaps ----------------
    clear_log();
    frame_q.push_back(8'hA5);
    push_basic_body();
    frame_q.push_back(8'h25);
    send_frame(3);
    check_status("gaps_release", 3'b010);
    check("gaps_words", {16'd0, words_loaded}, 32'd2);
    check_basic_writes("gaps");

    // ---------------- reset mid-frame ----------------
    clear_log();
    frame_q.push_back(8'hA5); frame_q.push_back(8'h02); frame_q.push_back(8'h00);
    frame_q.push_back(8'h20); frame_q.push_back(8'h08);
    frame_q.push_back(8'h00); frame_q.push_back(8'h05);
    frame_q.push_back(8'h00); frame_q.push_back(8'h00);
    send_frame(0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_im_we", {31'd0, im_we}, 32'd0);
    check("mid_rst_im_addr", im_addr, 32'd0);
    check("mid_rst_im_wdata", im_wdata, 32'd0);
    check_status("mid_rst_status", 3'b100);
    check("mid_rst_words", {16'd0, words_loaded}, 32'd0);
    rst = 1'b1;
    clear_log();
    frame_q.push_back(8'hA5);
    push_basic_body();
    frame_q.push_back(8'h25);
    send_frame(0);
    check_status("post_rst_release", 3'b010);
    check_basic_writes("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
